uart_tx_fifo_engine: RTL and testbench
======================================

// Module: uart_tx_fifo_engine
// PURPOSE
// - UART transmit path directly downstream of the APB register block.
// - Buffers bytes pushed by write_en/data_tx in a FIFO and serialises them onto tx_o.
// - Frame: start bit, 8 data bits LSB first, optional parity bit, 1 stop bit.
// - Paced by the 16x oversample tick from the baud generator.
// - Returns the tx_thr threshold flag, which the register block gates into itx_thr.
// PARAMETERS
// - DEPTH      16   FIFO entries; power of two, >=4
// - PTR_W      4    log2(DEPTH)
// - OVS        16   bclk_tick pulses per serial bit
// PORTS
// - pclk         in   1  system clock
// - presetn      in   1  asynchronous active-low reset
// - bclk_tick    in   1  one-pclk pulse, 16x baud rate
// - write_en     in   1  one-pclk push strobe from register block
// - data_tx      in   8  byte to push; sampled when write_en=1
// - ip_en        in   1  transmit enable
// - parity_en    in   1  1 = insert parity bit
// - parity_type  in   1  0 = even, 1 = odd
// - tx_thr_val   in   2  threshold select
// - tx_o         out  1  serial line, idle high
// - tx_thr       out  1  FIFO level at/below threshold
// - tx_full      out  1  FIFO count == DEPTH
// - tx_empty     out  1  FIFO count == 0
// - tx_busy      out  1  FSM not IDLE
// - tx_ovf       out  1  sticky: push dropped while full
// - tx_count     out  5  current FIFO count, 0..DEPTH
// BEHAVIOUR
// - Clock/reset: one clock pclk; presetn is asynchronous active-low.
// - Reset values:
//   - tx_o=1, tx_empty=1, tx_thr=1, tx_busy=0, tx_full=0, tx_ovf=0, tx_count=0.
//   - FIFO pointers, bit counter and tick counter cleared; state=IDLE.
// - Reset mid-frame: line returns high immediately; queued data is lost.
// - FIFO push:
//   - write_en=1 and not full: store data_tx at wr_ptr, wr_ptr+1 mod DEPTH.
//   - write_en=1 and full: byte dropped, tx_ovf set to 1.
//   - tx_ovf clears only on reset.
// - FIFO pop: occurs only in IDLE when ip_en=1 and not empty.
//   - Popped byte is loaded into the shift register.
//   - State becomes START on the next edge.
// - Simultaneous push and pop:
//   - Both happen; count is unchanged.
//   - Legal even when full: pop frees the slot, so no overflow.
// - Pointer wrap: modulo DEPTH; full/empty are derived from count, not pointer compare.
// - State machine:
//   - IDLE -> START -> DATA(8 bits) -> [PARITY if parity_en] -> STOP -> IDLE.
//   - tx_o per state: START=0, DATA=shift[0], PARITY=parity bit, STOP=1, IDLE=1.
// - Bit timing:
//   - tick_cnt (4b) is reset to 0 on entry to each state.
//   - tick_cnt increments on each bclk_tick.
//   - A bclk_tick with tick_cnt==OVS-1 ends the bit; each bit lasts exactly 16 ticks.
// - DATA state: shifts right on each bit end; bit_cnt counts 0..7 and exits after bit 7.
// - Parity:
//   - Computed as ^byte XOR parity_type at load time.
//   - parity_en and parity_type are sampled at load; mid-frame changes have no effect.
// - Back-to-back frames: from STOP end, if ip_en=1 and not empty, pop in the same cycle.
//   - START follows the next edge; the line holds stop level for that one extra pclk.
// - ip_en=0: the current frame completes; no new pop. FIFO still accepts pushes.
// - tx_thr is combinational from count:
//   - tx_thr_val 00: count==0
//   - tx_thr_val 01: count<=4
//   - tx_thr_val 10: count<=8
//   - tx_thr_val 11: count<=12
// - tx_busy=1 in every state except IDLE.
// - bclk_tick absent: FSM holds its current bit indefinitely; no timeout.
// TESTING
// - Basic frame (tick every 4 pclk, parity off): push 0x55 ->
//   - tx_o shows 0,1,0,1,0,1,0,1,0,1 at 64 pclk per bit.
//   - tx_busy spans 640 pclk.
// - Even parity: push 0xA3 with parity_en=1, type=0 ->
//   - parity bit=0; frame is 11 bits long.
//   - Odd type -> parity bit=1.
// - Fill and overflow: ip_en=0, push 17 bytes 0x00..0x10 ->
//   - tx_full=1, tx_count=16, tx_ovf=1.
//   - Enabling ip_en sends 0x00..0x0F in order.
// - Thresholds: push 5 bytes with ip_en=0 ->
//   - tx_thr=0 for sel 00 and 01; tx_thr=1 for sel 10 and 11.
// - Push while full and popping: full FIFO, push in the same cycle as a pop ->
//   - count stays 16, tx_ovf stays 0, byte sent last.
// - Reset mid-frame: assert presetn=0 during DATA bit 3 ->
//   - tx_o=1 and tx_count=0 immediately.
//   - No residual frame after release.

Source files
------------

// File: rtl/uart_tx_fifo_engine_if.sv
// Register-block side of the UART transmit engine: push strobe, frame controls and FIFO status.
// Latency: plain wires; timing is set by the engine behind the slave modport.
// Backpressure: none on the push strobe; a push into a full FIFO is dropped and flagged sticky.
interface uart_tx_fifo_engine_if;
  logic       write_en;
  logic [7:0] data_tx;
  logic       ip_en;
  logic       parity_en;
  logic       parity_type;
  logic [1:0] tx_thr_val;
  logic       tx_thr;
  logic       tx_full;
  logic       tx_empty;
  logic       tx_busy;
  logic       tx_ovf;
  logic [4:0] tx_count;

  modport master (
    output write_en, data_tx, ip_en, parity_en, parity_type, tx_thr_val,
    input  tx_thr, tx_full, tx_empty, tx_busy, tx_ovf, tx_count
  );

  modport slave (
    input  write_en, data_tx, ip_en, parity_en, parity_type, tx_thr_val,
    output tx_thr, tx_full, tx_empty, tx_busy, tx_ovf, tx_count
  );
endinterface

// File: rtl/uart_tx_fifo_engine.sv
// UART transmit engine: byte FIFO feeding a start/8-data/parity/stop serialiser on tx_o.
// Latency: a popped byte starts its start bit one pclk after the pop; each bit lasts OVS bclk_ticks.
// Backpressure: none upstream; a push while full is dropped (sticky tx_ovf) unless a pop frees the slot.
module uart_tx_fifo_engine #(
  parameter int DEPTH = 16,
  parameter int PTR_W = 4,
  parameter int OVS   = 16
) (
  input  logic pclk,
  input  logic presetn,
  input  logic bclk_tick,
  output logic tx_o,
  uart_tx_fifo_engine_if.slave rb
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  localparam logic [PTR_W:0] DEPTH_C   = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0] CNT_ONE   = (PTR_W+1)'(1);
  localparam logic [3:0]     TICK_LAST = 4'(OVS - 1);

  state_t           state, state_nxt;
  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count;
  logic [7:0]       head;
  logic [7:0]       shift;
  logic [3:0]       tick_cnt;
  logic [2:0]       bit_cnt;
  logic             par_bit, par_en;
  logic             full, empty, bit_end, pop, push, ovf;

  // FIFO status, bit timing strobe and push/pop qualification.
  always_comb begin
    full    = (count == DEPTH_C);
    empty   = (count == '0);
    head    = mem[rd_ptr];
    bit_end = bclk_tick && (tick_cnt == TICK_LAST);
    // A byte leaves the FIFO only from IDLE, so a frame ending in STOP always
    // passes through one IDLE pclk, which keeps the line at stop level for it.
    pop     = (state == IDLE) && rb.ip_en && !empty;
    // A pop in the same cycle frees a slot, so a push into a full FIFO is kept.
    push    = rb.write_en && (!full || pop);
  end

  // FIFO storage; no reset needed since contents are only read behind count.
  always_ff @(posedge pclk) begin
    if (push) mem[wr_ptr] <= rb.data_tx;
  end

  // FIFO pointers, occupancy and sticky overflow flag.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
      if (rb.write_en && full && !pop) ovf <= 1'b1;
    end
  end

  // Frame state register.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state and serial line value.
  always_comb begin
    state_nxt = state;
    tx_o      = 1'b1;
    case (state)
      IDLE: begin
        if (pop) state_nxt = START;
      end
      START: begin
        tx_o = 1'b0;
        if (bit_end) state_nxt = DATA;
      end
      DATA: begin
        tx_o = shift[0];
        if (bit_end && bit_cnt == 3'd7) state_nxt = par_en ? PARITY : STOP;
      end
      PARITY: begin
        tx_o = par_bit;
        if (bit_end) state_nxt = STOP;
      end
      STOP: begin
        if (bit_end) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Bit timing, shift register and per-frame parity captured at load.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      par_bit  <= 1'b0;
      par_en   <= 1'b0;
    end else begin
      // tick_cnt restarts on every state entry; within DATA it wraps at the bit end.
      if (state == IDLE || state_nxt != state) tick_cnt <= '0;
      else if (bclk_tick)                      tick_cnt <= tick_cnt + 1'b1;

      if (pop) begin
        shift   <= head;
        bit_cnt <= '0;
        par_bit <= (^head) ^ rb.parity_type;
        par_en  <= rb.parity_en;
      end else if (state == DATA && bit_end) begin
        shift   <= shift >> 1;
        bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end

  // Status back to the register block.
  always_comb begin
    rb.tx_full  = full;
    rb.tx_empty = empty;
    rb.tx_busy  = (state != IDLE);
    rb.tx_ovf   = ovf;
    rb.tx_count = 5'(count);
    case (rb.tx_thr_val)
      2'b00:   rb.tx_thr = (count == '0);
      2'b01:   rb.tx_thr = (count <= (PTR_W+1)'(4));
      2'b10:   rb.tx_thr = (count <= (PTR_W+1)'(8));
      default: rb.tx_thr = (count <= (PTR_W+1)'(12));
    endcase
  end

endmodule

// File: tb/tb_uart_tx_fifo_engine.sv
// Self-checking bench for uart_tx_fifo_engine: scoreboard of expected frames vs a serial-line monitor.
// Latency: monitor samples each bit near its centre, 64 pclk apart (tick every 4 pclk).
// Backpressure: exercises overflow, push-while-popping at full, and reset mid-frame.
module tb_uart_tx_fifo_engine;

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       pb;
  } exp_t;

  logic pclk;
  logic presetn;
  logic bclk_tick;
  logic tx_o;
  logic mon_en;
  int   n_vec;
  int   n_bad;
  int   div;
  exp_t exp_q[$];

  uart_tx_fifo_engine_if rb_if();

  uart_tx_fifo_engine dut (
    .pclk      (pclk),
    .presetn   (presetn),
    .bclk_tick (bclk_tick),
    .tx_o      (tx_o),
    .rb        (rb_if)
  );

  initial begin
    pclk = 1'b0;
    forever #5 pclk = ~pclk;
  end

  // 16x oversample tick: one pclk pulse every 4 pclk.
  initial begin
    bclk_tick = 1'b0;
    div = 0;
    forever begin
      @(posedge pclk);
      #1;
      div = (div + 1) % 4;
      bclk_tick = (div == 0);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got running want finished");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Serial-line monitor: decodes each frame and compares it with the scoreboard head.
  initial begin
    logic [7:0] d;
    logic       sb, pb, stp;
    exp_t       e;
    forever begin
      @(negedge pclk);
      if (mon_en && presetn && tx_o === 1'b0) begin
        if (exp_q.size() == 0) begin
          e.d = 8'h00; e.pe = 1'b0; e.pb = 1'b0;
          check("unexpected_frame", exp_q.size(), 1);
        end else begin
          e = exp_q[0];
        end
        repeat (31) @(negedge pclk);
        sb = tx_o;
        for (int i = 0; i < 8; i++) begin
          repeat (64) @(negedge pclk);
          d[i] = tx_o;
        end
        pb = 1'b0;
        if (e.pe) begin
          repeat (64) @(negedge pclk);
          pb = tx_o;
        end
        repeat (64) @(negedge pclk);
        stp = tx_o;
        check("start_bit", sb, 0);
        check("data_byte", d, e.d);
        if (e.pe) check("parity_bit", pb, e.pb);
        check("stop_bit", stp, 1);
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
    end
  end

  task automatic push(input logic [7:0] b);
    rb_if.write_en = 1'b1;
    rb_if.data_tx  = b;
    @(posedge pclk);
    #1;
    rb_if.write_en = 1'b0;
  endtask

  task automatic expect_frame(input logic [7:0] b, input logic pe, input logic ptype);
    exp_t e;
    e.d  = b;
    e.pe = pe;
    e.pb = (^b) ^ ptype;
    exp_q.push_back(e);
  endtask

  task automatic wait_idle(input int bound);
    int t;
    t = 0;
    while ((exp_q.size() != 0 || rb_if.tx_busy) && t < bound) begin
      @(negedge pclk);
      t++;
    end
    check("drain_timeout", (t >= bound), 0);
  endtask

  task automatic wait_busy(output logic ok);
    int t;
    t = 0;
    while (!rb_if.tx_busy && t < 200) begin
      @(negedge pclk);
      t++;
    end
    ok = rb_if.tx_busy;
  endtask

  task automatic count_busy(output int len);
    len = 1;
    forever begin
      @(negedge pclk);
      if (!rb_if.tx_busy || len > 3000) break;
      len++;
    end
  endtask

  task automatic do_reset();
    @(posedge pclk);
    #1;
    presetn = 1'b0;
    rb_if.write_en = 1'b0;
    repeat (3) @(posedge pclk);
    #1;
    presetn = 1'b1;
    exp_q.delete();
  endtask

  initial begin
    logic ok;
    int   len;
    int   lows;
    logic [3:0] exp_thr;
    n_vec = 0;
    n_bad = 0;
    mon_en = 1'b1;
    presetn = 1'b0;
    rb_if.write_en    = 1'b0;
    rb_if.data_tx     = 8'h00;
    rb_if.ip_en       = 1'b0;
    rb_if.parity_en   = 1'b0;
    rb_if.parity_type = 1'b0;
    rb_if.tx_thr_val  = 2'b00;
    repeat (4) @(posedge pclk);
    #1;
    check("rst_tx_o",     tx_o, 1);
    check("rst_empty",    rb_if.tx_empty, 1);
    check("rst_thr",      rb_if.tx_thr, 1);
    check("rst_busy",     rb_if.tx_busy, 0);
    check("rst_full",     rb_if.tx_full, 0);
    check("rst_ovf",      rb_if.tx_ovf, 0);
    check("rst_count",    rb_if.tx_count, 0);
    presetn = 1'b1;
    repeat (2) @(posedge pclk);
    #1;

    // Basic frame, parity off: 10 bits of 64 pclk each.
    rb_if.ip_en = 1'b1;
    expect_frame(8'h55, 1'b0, 1'b0);
    push(8'h55);
    wait_busy(ok);
    check("basic_busy_rise", ok, 1);
    count_busy(len);
    check("basic_busy_len", (len >= 637 && len <= 640), 1);
    wait_idle(2000);

    // Even parity; mid-frame control changes must not affect this frame.
    rb_if.parity_en = 1'b1;
    rb_if.parity_type = 1'b0;
    expect_frame(8'hA3, 1'b1, 1'b0);
    push(8'hA3);
    wait_busy(ok);
    check("par_busy_rise", ok, 1);
    rb_if.parity_type = 1'b1;
    rb_if.parity_en = 1'b0;
    count_busy(len);
    check("par_busy_len", (len >= 701 && len <= 704), 1);
    wait_idle(2000);

    // Odd parity.
    rb_if.parity_en = 1'b1;
    rb_if.parity_type = 1'b1;
    expect_frame(8'hA3, 1'b1, 1'b1);
    push(8'hA3);
    wait_idle(2000);
    rb_if.parity_en = 1'b0;
    rb_if.parity_type = 1'b0;

    // Fill and overflow with transmit disabled.
    rb_if.ip_en = 1'b0;
    for (int i = 0; i < 17; i++) begin
      if (i < 16) expect_frame(8'(i), 1'b0, 1'b0);
      push(8'(i));
    end
    check("fill_full",  rb_if.tx_full, 1);
    check("fill_count", rb_if.tx_count, 16);
    check("fill_ovf",   rb_if.tx_ovf, 1);
    check("fill_empty", rb_if.tx_empty, 0);
    rb_if.tx_thr_val = 2'b11;
    #1;
    check("fill_thr11", rb_if.tx_thr, 0);
    rb_if.ip_en = 1'b1;
    wait_idle(15000);
    check("drain_ovf_sticky", rb_if.tx_ovf, 1);
    check("drain_empty", rb_if.tx_empty, 1);
    do_reset();
    check("ovf_cleared", rb_if.tx_ovf, 0);

    // Thresholds at count 4 and 5.
    rb_if.ip_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      expect_frame(8'h10 + 8'(i), 1'b0, 1'b0);
      push(8'h10 + 8'(i));
    end
    rb_if.tx_thr_val = 2'b01;
    #1;
    check("thr01_cnt4", rb_if.tx_thr, 1);
    expect_frame(8'h14, 1'b0, 1'b0);
    push(8'h14);
    check("thr_count5", rb_if.tx_count, 5);
    exp_thr = 4'b1100;
    for (int s = 0; s < 4; s++) begin
      rb_if.tx_thr_val = 2'(s);
      #1;
      check("thr_cnt5_sel", rb_if.tx_thr, exp_thr[s]);
    end
    rb_if.ip_en = 1'b1;
    wait_idle(6000);

    // Push into a full FIFO in the same cycle as a pop.
    rb_if.ip_en = 1'b0;
    for (int i = 0; i < 16; i++) begin
      expect_frame(8'h80 + 8'(i), 1'b0, 1'b0);
      push(8'h80 + 8'(i));
    end
    check("pp_full", rb_if.tx_full, 1);
    expect_frame(8'hEE, 1'b0, 1'b0);
    rb_if.ip_en = 1'b1;
    push(8'hEE);
    check("pp_count", rb_if.tx_count, 16);
    check("pp_ovf", rb_if.tx_ovf, 0);
    check("pp_busy", rb_if.tx_busy, 1);
    wait_idle(15000);

    // Reset during DATA bit 3: line high at once, queue lost, nothing afterwards.
    mon_en = 1'b0;
    rb_if.ip_en = 1'b0;
    push(8'h3C);
    push(8'h11);
    push(8'h22);
    rb_if.ip_en = 1'b1;
    wait_busy(ok);
    check("mid_busy_rise", ok, 1);
    repeat (288) @(negedge pclk);
    check("mid_count_before", rb_if.tx_count, 2);
    presetn = 1'b0;
    #1;
    check("mid_rst_tx_o",  tx_o, 1);
    check("mid_rst_count", rb_if.tx_count, 0);
    check("mid_rst_busy",  rb_if.tx_busy, 0);
    repeat (3) @(posedge pclk);
    #1;
    presetn = 1'b1;
    lows = 0;
    for (int i = 0; i < 1500; i++) begin
      @(negedge pclk);
      if (tx_o !== 1'b1 || rb_if.tx_busy !== 1'b0) lows++;
    end
    check("mid_no_residual", lows, 0);
    check("mid_post_empty", rb_if.tx_empty, 1);
    mon_en = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
